// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div
//  Purpose  : Sequential restoring unsigned divider. Produces one quotient
//             bit per clock, MSB first, computing Q = A / B and R = A % B for
//             WIDTH-bit operands. Uses a start/fin handshake.
//
//  Ports    : ck     - clock, all state updates on the rising edge
//             rst    - asynchronous active-high reset
//             start  - request, sampled only while idle
//             A, B   - dividend / divisor, captured on the accepting edge
//             Q, R   - quotient / remainder, valid while fin=1 and held
//                      until the next result is written
//             busy   - high from the accepting edge until the result edge
//             fin    - one-cycle done pulse
//             div0   - divide-by-zero flag (only with SEQ_DIV_DIV0_EN)
//
//  Config   : SEQ_DIV_DIV0_EN - when defined, adds the div0 port and an
//             early exit for B==0 (result one cycle after accept). When not
//             defined, B==0 runs the normal algorithm (Q=all ones, R=A).
//
//  Revision : 1.0 - initial release
// ============================================================================
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             fin
`ifdef SEQ_DIV_DIV0_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_dvd;    // dividend shifts out MSB-first; quotient bits fill the LSBs
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_early;

`ifdef SEQ_DIV_DIV0_EN
    logic r_zero;
    assign w_early = r_zero;
`else
    assign w_early = 1'b0;
`endif

    // Trial subtraction on the WIDTH+1 bit partial remainder. When it
    // succeeds the true difference is below dvs, so the low WIDTH bits of
    // the wrapped subtraction are exact.
    assign w_t       = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_t >= {1'b0, r_dvs});
    assign w_diff    = w_t[WIDTH-1:0] - r_dvs;
    assign w_rem_nxt = w_ge ? w_diff : w_t[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            Q       <= '0;
            R       <= '0;
            busy    <= 1'b0;
            fin     <= 1'b0;
`ifdef SEQ_DIV_DIV0_EN
            r_zero  <= 1'b0;
            div0    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvd   <= A;
                        r_dvs   <= B;
                        r_rem   <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
`ifdef SEQ_DIV_DIV0_EN
                        r_zero  <= (B == '0);
                        div0    <= 1'b0;
`endif
                    end
                end

                ST_RUN: begin
                    if (w_early) begin
                        // Divide by zero: no iteration has run, so r_dvd still holds A.
                        Q       <= '1;
                        R       <= r_dvd;
                        busy    <= 1'b0;
                        fin     <= 1'b1;
                        r_state <= ST_DONE;
`ifdef SEQ_DIV_DIV0_EN
                        div0    <= 1'b1;
`endif
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_quo_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) begin
                            Q       <= w_quo_nxt;
                            R       <= w_rem_nxt;
                            busy    <= 1'b0;
                            fin     <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    fin     <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_div
//  Purpose  : Self-checking bench for seq_div (WIDTH=8): directed vector
//             table, ignored-start, asynchronous reset, back-to-back and a
//             random sweep against A/B, A%B.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       st = 1'b0;
    logic [7:0] da = '0;
    logic [7:0] db = '0;
    logic [7:0] q_o, r_o;
    logic       busy_o, fin_o;
`ifdef SEQ_DIV_DIV0_EN
    logic       d0_o;
    localparam int Z_LAT = 1;
`else
    localparam int Z_LAT = 8;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    seq_div #(.WIDTH(8)) dut (
        .ck    (ck),
        .rst   (rst),
        .start (st),
        .A     (da),
        .B     (db),
        .Q     (q_o),
        .R     (r_o),
        .busy  (busy_o),
        .fin   (fin_o)
`ifdef SEQ_DIV_DIV0_EN
        ,
        .div0  (d0_o)
`endif
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        int         lat;
        logic       d0;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_d0();
`ifdef SEQ_DIV_DIV0_EN
        return d0_o;
`else
        return 1'b0;
`endif
    endfunction

    // One complete operation from IDLE; lat=-1 means fin never arrived.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output int lat, output int bcnt,
                          output logic d0, output logic fin_one);
        lat = -1; bcnt = 0; q = '0; r = '0; d0 = 1'b0; fin_one = 1'b0;
        @(negedge ck);
        da = a; db = b; st = 1'b1;
        @(posedge ck);
        #1 st = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ck);
            if (busy_o) bcnt++;
            if (fin_o) begin
                lat = i - 1;
                q = q_o; r = r_o; d0 = get_d0();
                break;
            end
        end
        @(negedge ck);
        fin_one = !fin_o;
    endtask

    initial begin
        logic [7:0] q, r;
        int lat, bcnt, k, fins, f1, f2;
        logic d0, f1ok;
        logic [7:0] q1, r1, q2, r2;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   8,     1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   8,     1'b0};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   8,     1'b0};
        vecs[3] = '{8'd200, 8'd200, 8'd1,   8'd0,   8,     1'b0};
        vecs[4] = '{8'd37,  8'd0,   8'd255, 8'd37,  Z_LAT, 1'b1};
        vecs[5] = '{8'd254, 8'd16,  8'd15,  8'd14,  8,     1'b0};
        vecs[6] = '{8'd128, 8'd3,   8'd42,  8'd2,   8,     1'b0};
        vecs[7] = '{8'd0,   8'd5,   8'd0,   8'd0,   8,     1'b0};

        // Reset state
        #12;
        check("reset_Q", q_o, 0);
        check("reset_R", r_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_fin", fin_o, 0);
`ifdef SEQ_DIV_DIV0_EN
        check("reset_div0", d0_o, 0);
`endif
        @(negedge ck);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, q, r, lat, bcnt, d0, f1ok);
            check($sformatf("vec%0d_Q", i), q, vecs[i].q);
            check($sformatf("vec%0d_R", i), r, vecs[i].r);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].lat);
            check($sformatf("vec%0d_fin_one_cycle", i), f1ok, 1);
`ifdef SEQ_DIV_DIV0_EN
            check($sformatf("vec%0d_div0", i), d0, vecs[i].d0);
`endif
        end

        // start pulsed during RUN cycle 3 is ignored
        @(negedge ck);
        da = 8'd100; db = 8'd7; st = 1'b1;
        @(posedge ck);
        #1 st = 1'b0;
        repeat (3) @(negedge ck);
        st = 1'b1; da = 8'd9; db = 8'd2;
        @(negedge ck);
        st = 1'b0;
        lat = -1; q = '0; r = '0;
        for (int i = 5; i <= 40; i++) begin
            @(negedge ck);
            if (fin_o) begin
                lat = i - 1; q = q_o; r = r_o;
                break;
            end
        end
        check("ign_latency", lat, 8);
        check("ign_Q", q, 14);
        check("ign_R", r, 2);
        fins = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge ck);
            if (fin_o) fins++;
        end
        check("ign_no_second_fin", fins, 0);

        // Asynchronous reset in RUN cycle 4 (Q/R hold 14/2 beforehand)
        @(negedge ck);
        da = 8'd100; db = 8'd7; st = 1'b1;
        @(posedge ck);
        #1 st = 1'b0;
        repeat (4) @(negedge ck);
        #2 rst = 1'b1;
        #1;
        check("arst_Q", q_o, 0);
        check("arst_R", r_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_fin", fin_o, 0);
        @(negedge ck);
        rst = 1'b0;
        run_op(8'd100, 8'd7, q, r, lat, bcnt, d0, f1ok);
        check("post_rst_Q", q, 14);
        check("post_rst_R", r, 2);
        check("post_rst_latency", lat, 8);

        // Back-to-back with start held high; A/B change after accept
        @(negedge ck);
        da = 8'd100; db = 8'd7; st = 1'b1;
        @(posedge ck);
        #1 da = 8'd200; db = 8'd9;
        f1 = -1; f2 = -1; k = 0;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ck);
            if (fin_o) begin
                if (f1 < 0) begin
                    f1 = i; q1 = q_o; r1 = r_o;
                end else begin
                    f2 = i; q2 = q_o; r2 = r_o;
                    st = 1'b0;
                    break;
                end
            end
        end
        check("b2b_first_latency", f1 - 1, 8);
        check("b2b_first_Q", q1, 14);
        check("b2b_first_R", r1, 2);
        check("b2b_gap", f2 - f1, 10);
        check("b2b_second_Q", q2, 22);
        check("b2b_second_R", r2, 2);
        st = 1'b0;
        repeat (3) @(negedge ck);

        // Random sweep against A/B, A%B
        for (int n = 0; n < 150; n++) begin
            logic [7:0] a, b, eq, er;
            a = 8'($urandom_range(0, 255));
            b = (n % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            eq = (b == 0) ? 8'd255 : a / b;
            er = (b == 0) ? a : a % b;
            run_op(a, b, q, r, lat, bcnt, d0, f1ok);
            check($sformatf("rnd%0d_Q(%0d/%0d)", n, a, b), q, eq);
            check($sformatf("rnd%0d_R(%0d%%%0d)", n, a, b), r, er);
            check($sformatf("rnd%0d_latency", n), lat, (b == 0) ? Z_LAT : 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
